// File: rtl/inst_fetch_responder.sv
// Instruction-fetch memory responder: bus word read with timeout,
// misaligned-PC detection and a single-entry last-fetch record.
module inst_fetch_responder #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [31:0] PC,
    input  logic        flush,
    input  logic        inval,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err,
    output logic [31:0] MEM_inst,
    output logic        inst_valid,
    output logic        delay,
    output logic        IADEE,
    output logic        IADFE
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t      state, state_d;
    logic        mem_req_d;
    logic [31:0] mem_addr_d;
    logic [31:0] inst_d;
    logic        adee_d, adfe_d;
    logic [7:0]  cnt, cnt_d;
    logic [31:0] last_pc, last_pc_d;
    logic [31:0] last_inst, last_inst_d;
    logic        last_vld, last_vld_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            MEM_inst  <= '0;
            IADEE     <= 1'b0;
            IADFE     <= 1'b0;
            cnt       <= '0;
            last_pc   <= '0;
            last_inst <= '0;
            last_vld  <= 1'b0;
        end else begin
            state     <= state_d;
            mem_req   <= mem_req_d;
            mem_addr  <= mem_addr_d;
            MEM_inst  <= inst_d;
            IADEE     <= adee_d;
            IADFE     <= adfe_d;
            cnt       <= cnt_d;
            last_pc   <= last_pc_d;
            last_inst <= last_inst_d;
            last_vld  <= last_vld_d;
        end
    end

    always_comb begin
        state_d     = state;
        mem_req_d   = mem_req;
        mem_addr_d  = mem_addr;
        inst_d      = MEM_inst;
        adee_d      = IADEE;
        adfe_d      = IADFE;
        cnt_d       = cnt;
        last_pc_d   = last_pc;
        last_inst_d = last_inst;
        last_vld_d  = last_vld;
        case (state)
            ST_IDLE: begin
                if (fetch_req && !flush) begin
                    if (PC[1:0] != 2'b00) begin
                        state_d = ST_DONE;
                        adee_d  = 1'b1;
                        inst_d  = '0;
                    end else if (last_vld && PC == last_pc) begin
                        state_d = ST_DONE;
                        inst_d  = last_inst;
                    end else begin
                        state_d    = ST_WAIT;
                        mem_addr_d = {PC[31:2], 2'b00};
                        mem_req_d  = 1'b1;
                        cnt_d      = '0;
                    end
                end
            end
            ST_WAIT: begin
                if (flush && mem_ack) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end else if (mem_ack && mem_err) begin
                    state_d   = ST_DONE;
                    mem_req_d = 1'b0;
                    adfe_d    = 1'b1;
                    inst_d    = '0;
                end else if (mem_ack) begin
                    state_d     = ST_DONE;
                    mem_req_d   = 1'b0;
                    inst_d      = mem_rdata;
                    last_pc_d   = mem_addr;
                    last_inst_d = mem_rdata;
                    last_vld_d  = 1'b1;
                end else if (cnt == 8'(TIMEOUT - 1)) begin
                    // abort: slave must not ack once mem_req drops
                    state_d   = ST_DONE;
                    mem_req_d = 1'b0;
                    adfe_d    = 1'b1;
                    inst_d    = '0;
                end else if (cnt != 8'hFF) begin
                    cnt_d = cnt + 8'd1;
                end
            end
            ST_DRAIN: begin
                if (mem_ack) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                inst_d  = '0;
                adee_d  = 1'b0;
                adfe_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
        if (inval) last_vld_d = 1'b0;
    end

    assign inst_valid = (state == ST_DONE) && !flush;
    assign delay = (state == ST_WAIT) || (state == ST_DRAIN) ||
                   ((state == ST_IDLE) && fetch_req);

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Bench for inst_fetch_responder: directed scenarios plus random fetches
// checked against a transaction-level model of the last-fetch record.
module tb_inst_fetch_responder;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fetch_req = 1'b0;
    logic [31:0] PC = '0;
    logic        flush = 1'b0;
    logic        inval = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_err = 1'b0;
    logic [31:0] MEM_inst;
    logic        inst_valid;
    logic        delay;
    logic        IADEE;
    logic        IADFE;

    int vectors = 0;
    int miscompares = 0;

    // model of the last-fetch record
    bit          m_vld = 1'b0;
    logic [31:0] m_pc = '0;
    logic [31:0] m_inst = '0;

    inst_fetch_responder #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .PC(PC),
        .flush(flush), .inval(inval), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .mem_err(mem_err), .MEM_inst(MEM_inst), .inst_valid(inst_valid),
        .delay(delay), .IADEE(IADEE), .IADFE(IADFE)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_done(input string tag, input bit ade, input bit adf,
                            input logic [31:0] inst);
        chk({tag, ".valid"}, 32'(inst_valid), 32'd1);
        chk({tag, ".iadee"}, 32'(IADEE), 32'(ade));
        chk({tag, ".iadfe"}, 32'(IADFE), 32'(adf));
        chk({tag, ".inst"}, MEM_inst, inst);
        chk({tag, ".req"}, 32'(mem_req), 32'd0);
        chk({tag, ".delay"}, 32'(delay), 32'd0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".valid"}, 32'(inst_valid), 32'd0);
        chk({tag, ".iadee"}, 32'(IADEE), 32'd0);
        chk({tag, ".iadfe"}, 32'(IADFE), 32'd0);
        chk({tag, ".inst"}, MEM_inst, 32'd0);
        chk({tag, ".req"}, 32'(mem_req), 32'd0);
    endtask

    // One complete fetch; lat >= TO means the bus never answers.
    task automatic fetch(input string tag, input logic [31:0] pc,
                         input int lat, input bit err,
                         input logic [31:0] rdata);
        bit mis, hit;
        mis = (pc[1:0] != 2'b00);
        hit = !mis && m_vld && (pc == m_pc);
        @(negedge clk);
        fetch_req = 1'b1;
        PC = pc;
        #1;
        chk({tag, ".req_delay"}, 32'(delay), 32'd1);
        chk({tag, ".req_bus"}, 32'(mem_req), 32'd0);
        @(negedge clk);
        fetch_req = 1'b0;
        if (mis || hit) begin
            #1;
            chk_done({tag, ".fast"}, mis, 1'b0, mis ? 32'd0 : m_inst);
        end else begin
            for (int k = 0; k < TO; k++) begin
                #1;
                chk({tag, ".wreq"}, 32'(mem_req), 32'd1);
                chk({tag, ".waddr"}, mem_addr, pc);
                chk({tag, ".wdelay"}, 32'(delay), 32'd1);
                chk({tag, ".wvalid"}, 32'(inst_valid), 32'd0);
                if (k == lat) begin
                    mem_ack = 1'b1;
                    mem_err = err;
                    mem_rdata = rdata;
                end
                @(negedge clk);
                mem_ack = 1'b0;
                mem_err = 1'b0;
                mem_rdata = $urandom;
                if (k == lat) break;
            end
            #1;
            if (lat >= TO || err) begin
                chk_done({tag, ".fault"}, 1'b0, 1'b1, 32'd0);
            end else begin
                chk_done({tag, ".data"}, 1'b0, 1'b0, rdata);
                m_vld = 1'b1;
                m_pc = pc;
                m_inst = rdata;
            end
        end
        @(negedge clk);
        #1;
        chk_idle({tag, ".after"});
    endtask

    task automatic pulse_inval();
        @(negedge clk);
        inval = 1'b1;
        @(negedge clk);
        inval = 1'b0;
        m_vld = 1'b0;
    endtask

    logic [31:0] pcs [4];

    initial begin
        // reset state
        fetch_req = 1'b1;
        #3;
        chk("rst.req", 32'(mem_req), 32'd0);
        chk("rst.addr", mem_addr, 32'd0);
        chk("rst.inst", MEM_inst, 32'd0);
        chk("rst.valid", 32'(inst_valid), 32'd0);
        chk("rst.flags", {30'd0, IADEE, IADFE}, 32'd0);
        chk("rst.delay1", 32'(delay), 32'd1);
        fetch_req = 1'b0;
        #1;
        chk("rst.delay0", 32'(delay), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // miss, hit, invalidate then miss again
        fetch("boot", 32'hBFC0_0000, 3, 1'b0, 32'h3C08_BFC0);
        fetch("hit", 32'hBFC0_0000, 0, 1'b0, 32'h0);
        pulse_inval();
        fetch("inval", 32'hBFC0_0000, 0, 1'b0, 32'h3C08_BFC0);
        fetch("misal", 32'hBFC0_0006, 0, 1'b0, 32'h0);
        fetch("tmo", 32'h0000_1000, 99, 1'b0, 32'h0);
        fetch("err", 32'h0000_2000, 2, 1'b1, 32'hDEAD_BEEF);
        fetch("err_re", 32'h0000_2000, 1, 1'b0, 32'h1234_5678);

        // flush with fetch_req in IDLE: nothing starts
        @(negedge clk);
        fetch_req = 1'b1;
        PC = 32'h0000_3000;
        flush = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        flush = 1'b0;
        #1;
        chk_idle("idleflush");

        // flush in DONE suppresses inst_valid
        @(negedge clk);
        fetch_req = 1'b1;
        PC = 32'h0000_2000;
        @(negedge clk);
        fetch_req = 1'b0;
        flush = 1'b1;
        #1;
        chk("doneflush.valid", 32'(inst_valid), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk_idle("doneflush.after");

        // flush in 2nd WAIT cycle, drain, held request starts later
        @(negedge clk);
        fetch_req = 1'b1;
        PC = 32'h0000_4000;
        @(negedge clk);
        #1;
        chk("fl.w1req", 32'(mem_req), 32'd1);
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("fl.w2valid", 32'(inst_valid), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        PC = 32'h0000_2000;
        for (int d = 0; d < 4; d++) begin
            #1;
            chk("fl.dreq", 32'(mem_req), 32'd1);
            chk("fl.daddr", mem_addr, 32'h0000_4000);
            chk("fl.ddelay", 32'(delay), 32'd1);
            chk("fl.dvalid", 32'(inst_valid), 32'd0);
            if (d == 3) begin
                mem_ack = 1'b1;
                mem_rdata = 32'hAAAA_5555;
            end
            @(negedge clk);
            mem_ack = 1'b0;
        end
        #1;
        chk("fl.idle_req", 32'(mem_req), 32'd0);
        chk("fl.idle_valid", 32'(inst_valid), 32'd0);
        chk("fl.idle_delay", 32'(delay), 32'd1);
        @(negedge clk);
        fetch_req = 1'b0;
        #1;
        chk_done("fl.hit", 1'b0, 1'b0, 32'h1234_5678);
        @(negedge clk);
        fetch("fl.after", 32'h0000_4000, 5, 1'b0, 32'h0BAD_F00D);

        // reset mid-WAIT
        @(negedge clk);
        fetch_req = 1'b1;
        PC = 32'h0000_5000;
        @(negedge clk);
        fetch_req = 1'b0;
        #1;
        chk("rw.req", 32'(mem_req), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("rw.req0", 32'(mem_req), 32'd0);
        chk("rw.addr0", mem_addr, 32'd0);
        chk("rw.delay0", 32'(delay), 32'd0);
        chk_idle("rw.out");
        @(negedge clk);
        reset = 1'b1;
        m_vld = 1'b0;
        fetch("rw.miss", 32'h0000_4000, 2, 1'b0, 32'h7777_0001);

        // random traffic
        pcs[0] = 32'h0000_0100;
        pcs[1] = 32'h0000_0104;
        pcs[2] = 32'h8000_0000;
        pcs[3] = 32'hFFFF_FFFC;
        for (int t = 0; t < 60; t++) begin
            logic [31:0] p;
            int lat;
            bit e;
            p = pcs[$urandom_range(0, 3)];
            if ($urandom_range(0, 5) == 0) p[1:0] = 2'($urandom_range(1, 3));
            lat = ($urandom_range(0, 7) == 0) ? TO : $urandom_range(0, 6);
            e = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0) pulse_inval();
            fetch("rnd", p, lat, e, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/inst_fetch_responder.md
# inst_fetch_responder

Memory-side responder for the instruction-fetch stage. Accepts a fetch request carrying a PC, detects misaligned addresses, issues a word read on the instruction bus and tracks its latency with a timeout. Returns the instruction word, a stall indication and two exception flags to the fetch stage. A single-entry last-fetch record answers repeated PCs without a bus access.

## Interface
- TIMEOUT, 16: cycles in WAIT without `mem_ack` before a fetch fault is declared (range 2..255).
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- fetch_req  input  1  fetch request from the fetch stage; `PC` is valid while high.
- PC  input  32  fetch address.
- flush  input  1  interrupt/exception redirect; abandons the current fetch.
- inval  input  1  invalidates the last-fetch record.
- mem_req  output  1  bus read request; held high until `mem_ack` or abort.
- mem_addr  output  32  bus word address; bits [1:0] always 0.
- mem_ack  input  1  bus response strobe; valid only while `mem_req` is high.
- mem_rdata  input  32  bus read data, valid with `mem_ack`.
- mem_err  input  1  bus error, valid with `mem_ack`.
- MEM_inst  output  32  returned instruction word.
- inst_valid  output  1  one-cycle strobe: `MEM_inst`, `IADEE` and `IADFE` are valid.
- delay  output  1  stall to the fetch stage.
- IADEE  output  1  instruction address error (misaligned PC).
- IADFE  output  1  instruction fetch fault (bus error or timeout).

## Operation
- States: IDLE, WAIT, DRAIN, DONE. Reset enters IDLE.
- IDLE, `fetch_req`=1 and `flush`=0. Exactly one branch below applies, in priority order:
  - `PC[1:0]`≠0: go to DONE with `IADEE`=1, `MEM_inst`=0. No bus access.
  - Hit (`last_vld` and `PC`==`last_pc`): go to DONE with `MEM_inst`=`last_inst`. No bus access.
  - Otherwise: register `mem_addr`=`PC`, set `mem_req`=1, clear `cnt`=0, go to WAIT.
- WAIT, in priority order:
  - `flush`=1 with `mem_ack`: drop `mem_req`, go to IDLE, discard data.
  - `flush`=1 without `mem_ack`: go to DRAIN; `mem_req` stays high.
  - `mem_ack`, `mem_err`=1: go to DONE with `IADFE`=1, `MEM_inst`=0. Record unchanged.
  - `mem_ack`, `mem_err`=0: go to DONE with `MEM_inst`=`mem_rdata`. Load the record: `last_pc`=`mem_addr`, `last_inst`=`mem_rdata`, `last_vld`=1.
  - `cnt`==TIMEOUT-1: drop `mem_req` (abort), go to DONE with `IADFE`=1, `MEM_inst`=0.
  - Otherwise: `cnt`+1.
- DRAIN: hold `mem_req` until `mem_ack`, discard the response, then go to IDLE. No timeout in DRAIN. `fetch_req` is ignored.
- DONE: always returns to IDLE next cycle. `IADEE`, `IADFE` and `MEM_inst` are held for this one cycle and cleared to 0 on entry to IDLE.
- Combinational outputs:
  - `inst_valid` = (state==DONE) & ~`flush`.
  - `delay` = (state==WAIT) | (state==DRAIN) | (state==IDLE & `fetch_req`).
- `inval` clears `last_vld` in any state. If `inval` coincides with a record load, `inval` wins and `last_vld`=0.
- Bus rule: dropping `mem_req` before `mem_ack` aborts the access, and the slave must not ack afterwards. Any `mem_ack` in IDLE or DONE is ignored.
- `cnt` is 8 bits, saturating, and reset on each entry to WAIT.

## Timing
- Reset (asynchronous, `reset`=0) forces outputs immediately:
  - `mem_req`=0, `mem_addr`=0, `MEM_inst`=0, `IADEE`=0, `IADFE`=0, `inst_valid`=0.
  - `delay` follows `fetch_req`, because the state is IDLE.
  - Internal: `last_vld`=0, `cnt`=0.
- Reset during WAIT or DRAIN drops `mem_req` in the same instant. The access counts as aborted.
- Hit or misaligned: request seen in cycle N, `inst_valid` in cycle N+1. `delay`=1 in N only.
- Miss: `mem_req` rises in cycle N+1. If `mem_ack` arrives in cycle N+1+k, `inst_valid` is high in N+2+k. `delay` stays high from N through N+1+k.
- Timeout: `IADFE` with `inst_valid` in cycle N+1+TIMEOUT.
- `mem_addr` is stable for the whole time `mem_req` is high.
- `flush` with `fetch_req` in IDLE: `flush` wins and no fetch starts.
- `flush` in DONE suppresses `inst_valid`; the state still returns to IDLE.

## Test plan
- Reset, then PC=0xBFC0_0000 with `mem_ack` after 3 cycles and `mem_rdata`=0x3C08_BFC0 -> `mem_addr`=0xBFC0_0000, `inst_valid` 4 cycles after `mem_req` rises, `MEM_inst`=0x3C08_BFC0, `delay` low only in the DONE cycle.
- Re-request PC=0xBFC0_0000 -> no `mem_req`; `inst_valid` next cycle with 0x3C08_BFC0. Pulse `inval`, then request again -> a bus access occurs.
- PC=0xBFC0_0006 -> no `mem_req`; next cycle `inst_valid`=1, `IADEE`=1, `MEM_inst`=0.
- Miss with `mem_ack` never asserted, TIMEOUT=16 -> `mem_req` drops after 16 WAIT cycles; `IADFE`=1 with `inst_valid`. Separately, `mem_ack` with `mem_err`=1 -> `IADFE`=1 and the record is not updated (a re-request misses).
- `flush` in the 2nd WAIT cycle, `mem_ack` 4 cycles later -> state passes through DRAIN, no `inst_valid`, record unchanged. A new `fetch_req` held during DRAIN starts only after returning to IDLE.
- `reset` asserted mid-WAIT -> `mem_req`=0 immediately and all outputs return to reset values. After release, a fetch of the previously recorded PC misses.
